// File: rtl/daq_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : daq_event_fifo
// Brief    : Event-aware 64-bit word FIFO with a registered output stage,
//            cut-through or store-and-forward release and oversize release.
// Revision : 1.0 - initial release
// ============================================================================
module daq_event_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  dma_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [63:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [63:0]           out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    input  logic                  store_forward,
    output logic [DEPTH_LOG2:0]   words_stored,
    output logic [DEPTH_LOG2:0]   events_stored,
    output logic [31:0]           events_in_count,
    output logic [31:0]           events_out_count,
    output logic [15:0]           oversize_count
);

    localparam int unsigned           c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    logic [64:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_words;
    logic [DEPTH_LOG2:0]   r_events;
    logic                  r_mode_sf;
    logic                  r_oversize;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [63:0]           r_out_data;
    logic [31:0]           r_ev_in;
    logic [31:0]           r_ev_out;
    logic [15:0]           r_ovs_cnt;

    logic                  w_wr;
    logic                  w_xfer;
    logic                  w_in_last;
    logic                  w_out_last;
    logic                  w_out_hold_last;
    logic [DEPTH_LOG2:0]   w_mem_words;
    logic [DEPTH_LOG2:0]   w_mem_events;
    logic                  w_release;
    logic                  w_load;
    logic                  w_set_ovs;

    assign in_ready        = (r_words < c_FULL) && !reset;
    assign w_wr            = in_valid && in_ready;
    assign w_xfer          = r_out_valid && out_ready;
    assign w_in_last       = w_wr && in_last;
    assign w_out_last      = w_xfer && r_out_last;
    assign w_out_hold_last = r_out_valid && r_out_last;

    // Words and complete events still in memory, i.e. not yet in the output register.
    assign w_mem_words  = r_words  - (DEPTH_LOG2+1)'(r_out_valid);
    assign w_mem_events = r_events - (DEPTH_LOG2+1)'(w_out_hold_last);

    // Once the oversize event's last word sits in the output register, the
    // following event must again wait until it is complete.
    assign w_release = !r_mode_sf || (w_mem_events != '0) ||
                       (r_oversize && !w_out_hold_last);
    assign w_load    = (w_mem_words != '0) && (!r_out_valid || out_ready) && w_release;
    assign w_set_ovs = r_mode_sf && !r_oversize && (r_words == c_FULL) && (r_events == '0);

    always_ff @(posedge dma_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge dma_clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_words     <= '0;
            r_events    <= '0;
            r_mode_sf   <= 1'b0;
            r_oversize  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_ev_in     <= '0;
            r_ev_out    <= '0;
            r_ovs_cnt   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            if (w_load) begin
                r_rd_ptr                 <= r_rd_ptr + c_PTR_ONE;
                {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
                r_out_valid              <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            case ({w_wr, w_xfer})
                2'b10:   r_words <= r_words + c_CNT_ONE;
                2'b01:   r_words <= r_words - c_CNT_ONE;
                default: r_words <= r_words;
            endcase

            case ({w_in_last, w_out_last})
                2'b10:   r_events <= r_events + c_CNT_ONE;
                2'b01:   r_events <= r_events - c_CNT_ONE;
                default: r_events <= r_events;
            endcase

            if (w_in_last) begin
                r_ev_in <= r_ev_in + 32'd1;
            end
            if (w_out_last) begin
                r_ev_out <= r_ev_out + 32'd1;
            end

            if (r_words == '0) begin
                r_mode_sf <= store_forward;
            end

            if (w_set_ovs) begin
                r_oversize <= 1'b1;
                if (r_ovs_cnt != 16'hFFFF) begin
                    r_ovs_cnt <= r_ovs_cnt + 16'd1;
                end
            end else if (w_out_last) begin
                r_oversize <= 1'b0;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_last         = r_out_last;
    assign words_stored     = r_words;
    assign events_stored    = r_events;
    assign events_in_count  = r_ev_in;
    assign events_out_count = r_ev_out;
    assign oversize_count   = r_ovs_cnt;

endmodule
`default_nettype wire

// File: tb/tb_daq_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_daq_event_fifo
// Brief    : Randomized and directed self-checking bench for daq_event_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_daq_event_fifo;

    localparam int DL2  = 9;
    localparam int FULL = 1 << DL2;
    localparam int N_EV = 800;

    logic          dma_clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [63:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [63:0]   out_data;
    logic          out_last;
    logic          out_ready;
    logic          store_forward = 1'b0;
    logic [DL2:0]  words_stored;
    logic [DL2:0]  events_stored;
    logic [31:0]   events_in_count;
    logic [31:0]   events_out_count;
    logic [15:0]   oversize_count;

    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b0;
    logic dir_rdy  = 1'b0;
    assign out_ready = rand_rdy ? rnd_bit : dir_rdy;

    daq_event_fifo #(.DEPTH_LOG2(DL2)) dut (
        .dma_clk          (dma_clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .store_forward    (store_forward),
        .words_stored     (words_stored),
        .events_stored    (events_stored),
        .events_in_count  (events_in_count),
        .events_out_count (events_out_count),
        .oversize_count   (oversize_count)
    );

    always #5 dma_clk = ~dma_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural model: ordered word queue plus counters derived from transfers.
    logic [64:0] sbq[$];
    int          m_words  = 0;
    int          m_events = 0;
    logic [31:0] m_ev_in  = '0;
    logic [31:0] m_ev_out = '0;
    logic [15:0] m_ovs_cnt = '0;
    bit          m_mode = 0;
    bit          m_ovs  = 0;
    bit          started = 0;
    bit          prev_rst = 0;
    bit          prev_hold = 0;
    bit          prev_ct_mem = 0;
    int          max_words = 0;
    bit          saw_full = 0;
    int          n_xfer = 0;

    initial forever begin
        @(posedge dma_clk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [64:0] e;
        int          w0;
        bit          acc, xfer, set_ovs;
        forever begin
            @(negedge dma_clk);
            if (reset) begin
                if (started) chk("rst_in_ready_low", in_ready, 0);
                started = 1;
                prev_rst = 1;
                sbq.delete();
                m_words = 0; m_events = 0; m_ev_in = '0; m_ev_out = '0;
                m_ovs_cnt = '0; m_mode = 0; m_ovs = 0;
                prev_hold = 0; prev_ct_mem = 0;
            end else if (started) begin
                if (prev_rst) begin
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_out_data", out_data, 0);
                    chk("rst_out_last", out_last, 0);
                end
                chk("in_ready", in_ready, m_words < FULL);
                chk("words_stored", words_stored, m_words);
                chk("events_stored", events_stored, m_events);
                chk("events_in_count", events_in_count, m_ev_in);
                chk("events_out_count", events_out_count, m_ev_out);
                chk("oversize_count", oversize_count, m_ovs_cnt);
                if (prev_hold) chk("hold_valid", out_valid, 1);
                if (prev_ct_mem) chk("ct_no_bubble", out_valid, 1);
                if (m_mode && !m_ovs && m_events == 0) chk("sf_hold", out_valid, 0);
                if (out_valid) begin
                    if (sbq.size() == 0) chk("unexpected_word", out_valid, 0);
                    else begin
                        chk("out_data", out_data, sbq[0][63:0]);
                        chk("out_last", out_last, sbq[0][64]);
                    end
                end
                if (int'(words_stored) > max_words) max_words = int'(words_stored);
                if (!in_ready) saw_full = 1;

                w0          = m_words;
                acc         = in_valid && (m_words < FULL);
                xfer        = out_valid && out_ready;
                set_ovs     = m_mode && !m_ovs && (m_words == FULL) && (m_events == 0);
                prev_hold   = out_valid && !out_ready;
                prev_ct_mem = !m_mode && ((m_words - (out_valid ? 1 : 0)) >= 1);
                if (xfer && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    m_words--;
                    n_xfer++;
                    if (e[64]) begin
                        m_events--;
                        m_ev_out++;
                        m_ovs = 0;
                    end
                end
                if (set_ovs) begin
                    m_ovs = 1;
                    if (m_ovs_cnt != 16'hFFFF) m_ovs_cnt++;
                end
                if (acc) begin
                    sbq.push_back({in_last, in_data});
                    m_words++;
                    if (in_last) begin
                        m_events++;
                        m_ev_in++;
                    end
                end
                if (w0 == 0) m_mode = store_forward;
                prev_rst = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge dma_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input bit last);
        bit acc;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 5000);
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((words_stored != 0 || out_valid) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_done", words_stored, 0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int first, lastc, nval, x0, len;
        repeat (3) tick();
        chk("rst_words", words_stored, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Cut-through 4-word event: output cycles +2..+5
        store_forward = 1'b0;
        dir_rdy = 1'b1;
        tick(); tick();
        first = -1; lastc = -1; nval = 0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 4);
            in_data  = 64'hA000 + 64'(t);
            in_last  = (t == 3);
            if (out_valid) begin
                if (first < 0) first = t;
                nval++;
                if (out_last) lastc = t;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("ct_first_valid", first, 2);
        chk("ct_last_cycle", lastc, 5);
        chk("ct_valid_cycles", nval, 4);
        chk("ct_ev_out", events_out_count, 1);
        drain(100);

        // Store-and-forward 8-word event: output starts two cycles after in_last
        store_forward = 1'b1;
        tick(); tick();
        first = -1;
        for (int t = 0; t < 16; t++) begin
            in_valid = (t < 8);
            in_data  = 64'hB000 + 64'(t);
            in_last  = (t == 7);
            if (out_valid && first < 0) first = t;
            if (t == 8) chk("sf_events_stored", events_stored, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("sf_first_valid", first, 9);
        drain(100);

        // Oversize 600-word event in store-and-forward, then a short event
        max_words = 0;
        saw_full = 0;
        for (int i = 0; i < 600; i++) send(64'hC0000 + 64'(i), i == 599);
        for (int i = 0; i < 3; i++) send(64'hC1000 + 64'(i), i == 2);
        drain(2000);
        chk("ovs_max_words", max_words, 512);
        chk("ovs_in_ready_dropped", saw_full, 1);
        chk("ovs_count", oversize_count, 1);
        chk("ovs_ev_out", events_out_count, 4);

        // Cut-through fill to capacity with output stalled, then one transfer
        pulse_reset();
        store_forward = 1'b0;
        dir_rdy = 1'b0;
        tick();
        for (int i = 0; i < 512; i++) send(64'hD0000 + 64'(i), (i % 64) == 63);
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        in_last  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("full_in_ready", in_ready, 0);
            chk("full_words", words_stored, 512);
            tick();
        end
        in_valid = 1'b0;
        x0 = n_xfer;
        dir_rdy = 1'b1;
        tick();
        dir_rdy = 1'b0;
        chk("pulse_in_ready", in_ready, 1);
        chk("pulse_words", words_stored, 511);
        repeat (3) tick();
        chk("pulse_one_word", n_xfer - x0, 1);
        dir_rdy = 1'b1;
        drain(2000);
        chk("full_ev_out", events_out_count, 8);

        // Reset mid-event with 100 words stored
        pulse_reset();
        dir_rdy = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) send(64'hE0000 + 64'(i), 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_words", words_stored, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        tick();
        dir_rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(64'hE1000 + 64'(i), i == 4);
        drain(100);
        chk("midrst_ev_out", events_out_count, 1);

        // Random events, random gaps and stalls, random mode requests
        pulse_reset();
        rand_rdy = 1'b1;
        for (int e = 0; e < N_EV; e++) begin
            store_forward = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                send({$urandom, $urandom}, w == len - 1);
            end
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        dir_rdy = 1'b1;
        drain(5000);
        chk("rand_ev_in", events_in_count, N_EV);
        chk("rand_ev_out", events_out_count, N_EV);
        chk("rand_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
